// File: rtl/fp_mul_arbiter.sv
// Round-robin sequencer sharing one FP multiplier (start/done handshake) among NUM_REQ clients.
// Optional watchdog enabled by defining FPMUL_ARB_TIMEOUT_EN (times out after TIMEOUT WAIT cycles).
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  op1_bus,
  input  logic [32*NUM_REQ-1:0]  op2_bus,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic                   busy,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   mul_start,
  output logic [31:0]            mul_op1,
  output logic [31:0]            mul_op2,
  input  logic                   mul_done,
  input  logic [31:0]            mul_res
);

  localparam int DATA_W = 32;

  if (IDX_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_chk
    $error("fp_mul_arbiter: inconsistent NUM_REQ/IDX_W/TIMEOUT");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   res_sel;
  logic                wd_expire;
  logic                wait_exit;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    int idx;
    rr_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (r[idx]) rr_pick = IDX_W'(idx);
    end
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    next_ptr = IDX_W'((int'(g) + 1) % NUM_REQ);
  endfunction

  assign win       = rr_pick(req, ptr);
  assign wait_exit = (state == S_WAIT) && (mul_done || wd_expire);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_exit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and operand latch stage
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      mul_op1 <= '0;
      mul_op2 <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && |req) begin
        gnt_idx <= win;
        mul_op1 <= op1_bus[32*win +: 32];
        mul_op2 <= op2_bus[32*win +: 32];
      end
      if (state == S_RESP) ptr <= next_ptr(gnt_idx);
    end
  end

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int                WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  logic [WD_W-1:0] wdog;
  logic            err_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 1'b1;
      if (wait_exit)            err_q <= ~mul_done;
    end
  end

  // A real done in the expiring cycle still wins over the timeout.
  assign wd_expire = (state == S_WAIT) && (wdog == WD_W'(TIMEOUT - 1));
  assign res_sel   = mul_done ? mul_res : QNAN;
  assign resp_err  = (state == S_RESP) && err_q;
`else
  assign wd_expire = 1'b0;
  assign res_sel   = mul_res;
  assign resp_err  = 1'b0;
`endif

  // Result capture stage; data path is not reset since it is gated by state
  always_ff @(posedge pclk) begin
    if (wait_exit) res_q <= res_sel;
  end

  assign busy       = (state != S_IDLE);
  assign mul_start  = (state == S_ISSUE);
  assign resp_valid = (state == S_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign resp_data  = (state == S_RESP) ? res_q : '0;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter with an abstract round-robin/multiplier reference model.
module tb_fp_mul_arbiter;
  localparam int N  = 4;
  localparam int TO = 10;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic [N-1:0]  req = '0;
  logic [127:0]  op1_bus = '0;
  logic [127:0]  op2_bus = '0;
  logic [N-1:0]  resp_valid;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          busy;
  logic [1:0]    gnt_idx;
  logic          mul_start;
  logic [31:0]   mul_op1;
  logic [31:0]   mul_op2;
  logic          mul_done = 1'b0;
  logic [31:0]   mul_res = '0;

  int            total = 0;
  int            bad = 0;
  int            ptr_m = 0;
  logic [31:0]   a_m [N];
  logic [31:0]   b_m [N];

  always #5 pclk = ~pclk;

  fp_mul_arbiter #(.NUM_REQ(N), .IDX_W(2), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .op1_bus(op1_bus), .op2_bus(op2_bus),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .gnt_idx(gnt_idx), .mul_start(mul_start), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_done(mul_done), .mul_res(mul_res)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    a_m[i] = a;
    b_m[i] = b;
    op1_bus[32*i +: 32] = a;
    op2_bus[32*i +: 32] = b;
  endtask

  function automatic int pick_model();
    for (int k = 0; k < N; k++)
      if (req[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // One full transaction: multiplier answers lat+1 cycles after it sees start.
  task automatic do_op(input int lat, input logic [31:0] res,
                       output int idx, output int sw, output int cyc);
    cyc = 0;
    sw  = -1;
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cyc++;
      if (mul_start === 1'b1) break;
      chk("idle_data_zero", resp_data, 32'h0);
    end
    if (mul_start !== 1'b1) begin
      chk("start_seen", {31'b0, mul_start}, 32'h1);
      return;
    end
    sw  = cyc;
    idx = pick_model();
    chk("gnt_idx", {30'b0, gnt_idx}, 32'(idx));
    chk("mul_op1", mul_op1, a_m[idx]);
    chk("mul_op2", mul_op2, b_m[idx]);
    chk("busy_issue", {31'b0, busy}, 32'h1);
    for (int k = 0; k <= lat; k++) begin
      tick();
      cyc++;
    end
    chk("wait_no_resp", {28'b0, resp_valid}, 32'h0);
    mul_done = 1'b1;
    mul_res  = res;
    tick();
    cyc++;
    mul_done = 1'b0;
    mul_res  = $urandom;
    chk("resp_valid", {28'b0, resp_valid}, 32'h1 << idx);
    chk("resp_data", resp_data, res);
    chk("resp_err", {31'b0, resp_err}, 32'h0);
    ptr_m = (idx + 1) % N;
  endtask

  initial begin
    int idx, sw, cyc;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [31:0] r;

    for (int i = 0; i < N; i++) set_op(i, 32'h0, 32'h0);

    // Reset state
    #2;
    chk("rst_resp_valid", {28'b0, resp_valid}, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_gnt", {30'b0, gnt_idx}, 32'h0);
    chk("rst_start", {31'b0, mul_start}, 32'h0);
    chk("rst_op1", mul_op1, 32'h0);
    chk("rst_op2", mul_op2, 32'h0);
    chk("rst_err", {31'b0, resp_err}, 32'h0);
    tick();
    presetn = 1'b1;
    tick();

    // All requesters held high: strict 0,1,2,3,0 rotation
    for (int i = 0; i < N; i++) set_op(i, 32'h3FC0_0000, 32'h3FC0_0000);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_op(2, 32'h4010_0000, idx, sw, cyc);
      chk("rr_order", 32'(idx), 32'(exp_seq[i]));
      chk("rr_gap", 32'(sw), (i == 0) ? 32'd1 : 32'd2);
    end
    req = 4'b0000;
    tick();

    // Single request, multiplier latency 5: response 8 cycles after req
    set_op(0, 32'h4000_0000, 32'h4040_0000);
    req = 4'b0001;
    do_op(5, 32'h40C0_0000, idx, sw, cyc);
    chk("lat_start", 32'(sw), 32'd1);
    chk("lat_total", 32'(cyc), 32'd8);
    req = 4'b0000;
    tick();

    // Serve requester 2, then 0101 must wrap to requester 0
    set_op(2, $urandom, $urandom);
    req = 4'b0100;
    do_op(1, 32'h1234_5678, idx, sw, cyc);
    chk("wrap_first", 32'(idx), 32'd2);
    req = 4'b0101;
    do_op(0, 32'h0BAD_F00D, idx, sw, cyc);
    chk("wrap_second", 32'(idx), 32'd0);
    req = 4'b0000;
    tick();

    // Stray done in IDLE and in ISSUE must be ignored
    set_op(3, 32'h4100_0000, 32'h3F00_0000);
    req = 4'b1000;
    mul_done = 1'b1;
    mul_res = 32'hDEAD_BEEF;
    tick();
    chk("ign_start", {31'b0, mul_start}, 32'h1);
    tick();
    mul_done = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("ign_busy", {31'b0, busy}, 32'h1);
    chk("ign_no_resp", {28'b0, resp_valid}, 32'h0);
    mul_done = 1'b1;
    mul_res = 32'h4080_0000;
    tick();
    mul_done = 1'b0;
    chk("ign_resp_valid", {28'b0, resp_valid}, 32'h8);
    chk("ign_resp_data", resp_data, 32'h4080_0000);
    ptr_m = 0;
    req = 4'b0000;
    tick();

    // No done from the multiplier: watchdog or indefinite wait
    set_op(2, $urandom, $urandom);
    req = 4'b0100;
    tick();
    chk("to_start", {31'b0, mul_start}, 32'h1);
`ifdef FPMUL_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) tick();
    chk("to_not_early", {28'b0, resp_valid}, 32'h0);
    tick();
    chk("to_resp_valid", {28'b0, resp_valid}, 32'h4);
    chk("to_resp_data", resp_data, 32'h7FC0_0000);
    chk("to_resp_err", {31'b0, resp_err}, 32'h1);
    req = 4'b0000;
    tick();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    chk("to_stray_busy", {31'b0, busy}, 32'h0);
    chk("to_stray_resp", {28'b0, resp_valid}, 32'h0);
`else
    for (int k = 0; k < 30; k++) tick();
    chk("hold_busy", {31'b0, busy}, 32'h1);
    chk("hold_no_resp", {28'b0, resp_valid}, 32'h0);
    mul_done = 1'b1;
    mul_res = 32'h3F80_0000;
    tick();
    mul_done = 1'b0;
    chk("hold_resp_valid", {28'b0, resp_valid}, 32'h4);
    chk("hold_resp_data", resp_data, 32'h3F80_0000);
    req = 4'b0000;
`endif
    ptr_m = 3;
    tick();

    // Reset while waiting: operation discarded, pointer back to 0
    set_op(1, $urandom, $urandom);
    req = 4'b0010;
    tick();
    tick();
    tick();
    presetn = 1'b0;
    req = 4'b0000;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_gnt", {30'b0, gnt_idx}, 32'h0);
    chk("mid_rst_op1", mul_op1, 32'h0);
    chk("mid_rst_op2", mul_op2, 32'h0);
    chk("mid_rst_resp", {28'b0, resp_valid}, 32'h0);
    tick();
    presetn = 1'b1;
    ptr_m = 0;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    tick();
    chk("post_rst_resp", {28'b0, resp_valid}, 32'h0);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    set_op(0, 32'hBF80_0000, 32'h4080_0000);
    set_op(3, $urandom, $urandom);
    req = 4'b1001;
    do_op(3, 32'hC080_0000, idx, sw, cyc);
    chk("post_rst_idx", 32'(idx), 32'd0);
    req = 4'b0000;
    tick();

    // Randomised traffic against the round-robin model
    for (int n = 0; n < 40; n++) begin
      if (req == 4'b0000) begin
        int j = $urandom_range(0, N - 1);
        set_op(j, $urandom, $urandom);
        req[j] = 1'b1;
      end
      r = $urandom;
      do_op($urandom_range(0, 4), r, idx, sw, cyc);
      req[idx] = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (!req[j] && ($urandom_range(0, 2) == 0)) begin
          set_op(j, $urandom, $urandom);
          req[j] = 1'b1;
        end
      end
    end
    req = 4'b0000;
    tick();
    tick();
    chk("final_idle", {31'b0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
